// File: rtl/param_register_file_if.sv
// Bus bundle for param_register_file: write port, packed read ports, clear request and ready.
// The master drives requests and addresses; the slave (the register file) returns read data and ready.
interface param_register_file_if #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 5,
    parameter int NUM_READ_PORTS = 2
) ();

    logic                                 clear_request;
    logic                                 write_enable;
    logic [ADDR_WIDTH-1:0]                write_address;
    logic [DATA_WIDTH-1:0]                write_data;
    logic [NUM_READ_PORTS*ADDR_WIDTH-1:0] read_address;
    logic [NUM_READ_PORTS*DATA_WIDTH-1:0] read_data;
    logic                                 ready;

    modport master (
        output clear_request,
        output write_enable,
        output write_address,
        output write_data,
        output read_address,
        input  read_data,
        input  ready
    );

    modport slave (
        input  clear_request,
        input  write_enable,
        input  write_address,
        input  write_data,
        input  read_address,
        output read_data,
        output ready
    );

endinterface

// File: rtl/param_register_file.sv
// Parametrised register file with a hardware clear sequencer; the array itself has no reset.
// Optional macro REGFILE_BYPASS_EN adds a same-cycle write-to-read bypass.
module param_register_file #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 5,
    parameter int NUM_READ_PORTS = 2,
    parameter int ZERO_REG       = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    param_register_file_if.slave  bus,
    output logic                  state_debug
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] LAST_INDEX = (ADDR_WIDTH + 1)'(DEPTH - 1);

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    state_t                state;
    logic                  ready_q;
    logic [ADDR_WIDTH:0]   clear_index;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                                 write_blocked;
    logic                                 user_write;
    logic [NUM_READ_PORTS*DATA_WIDTH-1:0] read_data_comb;

    // Handshake: a write_enable or clear_request is taken at the rising edge only while
    // ready=1; while ready=0 both are dropped (never queued), and a clear_request wins
    // over a write presented in the same cycle.
    assign write_blocked = (ZERO_REG != 0) && (bus.write_address == '0);
    assign user_write    = (state == READY) && bus.write_enable
                           && !bus.clear_request && !write_blocked;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= CLEAR;
            ready_q     <= 1'b0;
            clear_index <= '0;
        end else begin
            case (state)
                CLEAR: begin
                    clear_index <= clear_index + 1'b1;
                    if (clear_index == LAST_INDEX) begin
                        state   <= READY;
                        ready_q <= 1'b1;
                    end
                end
                READY: begin
                    if (bus.clear_request) begin
                        state       <= CLEAR;
                        ready_q     <= 1'b0;
                        clear_index <= '0;
                    end
                end
                default: begin
                    state       <= CLEAR;
                    ready_q     <= 1'b0;
                    clear_index <= '0;
                end
            endcase
        end
    end

    // The clear sequencer owns the write port while clearing.
    always_ff @(posedge clock) begin
        if (state == CLEAR) begin
            mem[clear_index[ADDR_WIDTH-1:0]] <= '0;
        end else if (user_write) begin
            mem[bus.write_address] <= bus.write_data;
        end
    end

    always_comb begin
        logic [ADDR_WIDTH-1:0] addr;
        read_data_comb = '0;
        addr           = '0;
        for (int k = 0; k < NUM_READ_PORTS; k++) begin
            addr = bus.read_address[k*ADDR_WIDTH +: ADDR_WIDTH];
            if (state == READY && !((ZERO_REG != 0) && (addr == '0))) begin
                read_data_comb[k*DATA_WIDTH +: DATA_WIDTH] = mem[addr];
`ifdef REGFILE_BYPASS_EN
                if (ready_q && bus.write_enable && (addr == bus.write_address)) begin
                    read_data_comb[k*DATA_WIDTH +: DATA_WIDTH] = bus.write_data;
                end
`endif
            end
        end
    end

    assign bus.read_data = read_data_comb;
    assign bus.ready     = ready_q;
    assign state_debug   = state;

endmodule
